// File: rtl/cursor_controller.sv
// ----------------------------------------------------------------------------
// cursor_controller
//
// Owns the selected-cell cursor of the board. It turns the player's direction
// buttons into registered row/col indices that feed the cell-to-pixel mapper.
// The indices wrap around at the board edges. Holding a direction auto-repeats
// the step. A free-running blink phase tells the renderer when to draw.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   btn_up     debounced/synchronised level, active-high
//   btn_down   debounced/synchronised level, active-high
//   btn_left   debounced/synchronised level, active-high
//   btn_right  debounced/synchronised level, active-high
//   enable     1 = cursor may move (game in play)
//   row        selected row, 0 = top
//   col        selected column, 0 = left
//   blink_on   1 = draw the cursor in this phase
//   moved      one-cycle pulse, high in the cycle row/col show a new value
// ----------------------------------------------------------------------------
module cursor_controller #(
    parameter int GRID_SIZE     = 9,
    parameter int HOLD_CYCLES   = 25_000_000,
    parameter int REPEAT_CYCLES = 5_000_000,
    parameter int BLINK_CYCLES  = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       enable,
    output logic [3:0] row,
    output logic [3:0] col,
    output logic       blink_on,
    output logic       moved
);

    // One counter is shared between the hold and repeat phases, so it is
    // sized for whichever interval is longer.
    localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [CNT_W-1:0]   HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST  = BLINK_W'(BLINK_CYCLES - 1);
    localparam logic [3:0]         GRID_LAST   = 4'(GRID_SIZE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT
    } state_t;

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    state_t              state;
    state_t              state_next;
    dir_t                dir;
    dir_t                last_dir;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic [BLINK_W-1:0]  blink_cnt;
    logic                step;

    // Wrap-around index arithmetic. Indices always stay in 0..GRID_SIZE-1.
    function automatic logic [3:0] wrap_inc(input logic [3:0] idx);
        return (idx == GRID_LAST) ? 4'd0 : idx + 4'd1;
    endfunction

    function automatic logic [3:0] wrap_dec(input logic [3:0] idx);
        return (idx == 4'd0) ? GRID_LAST : idx - 4'd1;
    endfunction

    // A direction is valid only when exactly one button is pressed. Chords
    // count as no direction, so the cursor never moves diagonally or
    // ambiguously.
    always_comb begin
        dir = DIR_NONE;
        case ({btn_up, btn_down, btn_left, btn_right})
            4'b1000: dir = DIR_UP;
            4'b0100: dir = DIR_DOWN;
            4'b0010: dir = DIR_LEFT;
            4'b0001: dir = DIR_RIGHT;
            default: dir = DIR_NONE;
        endcase
    end

    // Hold / auto-repeat FSM: next state, counter and step request.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        step       = 1'b0;

        if (!enable) begin
            // Disabled: park in IDLE. When enable rises again, a held button
            // then counts as a fresh press.
            state_next = ST_IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (dir != DIR_NONE) begin
                        step       = 1'b1;
                        cnt_next   = '0;
                        state_next = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (dir == DIR_NONE) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end else if (dir != last_dir) begin
                        step     = 1'b1;
                        cnt_next = '0;
                    end else if (cnt == HOLD_LAST) begin
                        step       = 1'b1;
                        cnt_next   = '0;
                        state_next = ST_REPEAT;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (dir == DIR_NONE) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end else if (dir != last_dir) begin
                        // A new direction must wait out the full hold delay
                        // again before it starts repeating.
                        step       = 1'b1;
                        cnt_next   = '0;
                        state_next = ST_HOLD;
                    end else if (cnt == REPEAT_LAST) begin
                        step     = 1'b1;
                        cnt_next = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Cursor position. The direction is latched on every step so that HOLD
    // and REPEAT can tell a change of direction from a continued hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row      <= 4'd0;
            col      <= 4'd0;
            last_dir <= DIR_NONE;
            moved    <= 1'b0;
        end else begin
            moved <= step;
            if (step) begin
                last_dir <= dir;
                case (dir)
                    DIR_UP:    row <= wrap_dec(row);
                    DIR_DOWN:  row <= wrap_inc(row);
                    DIR_LEFT:  col <= wrap_dec(col);
                    DIR_RIGHT: col <= wrap_inc(col);
                    default:   ;
                endcase
            end
        end
    end

    // Blink phase. A step restarts a full visible half-period so that the
    // cursor is always shown right after it moves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_on  <= 1'b1;
            blink_cnt <= '0;
        end else if (step) begin
            blink_on  <= 1'b1;
            blink_cnt <= '0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_on  <= ~blink_on;
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_cursor_controller.sv
// ----------------------------------------------------------------------------
// tb_cursor_controller
//
// Directed stimulus for cursor_controller with short timing parameters.
// A behavioural model tracks how long the current direction has been held
// and how long it has been since the blink phase last restarted. The model
// derives the expected outputs from those durations. A negedge compare
// process checks every output on every cycle outside reset. Hand-computed
// literal checks pin the model to known values at key points.
// ----------------------------------------------------------------------------
module tb_cursor_controller;

    localparam int GRID   = 9;
    localparam int HOLD   = 4;
    localparam int REPEAT = 2;
    localparam int BLINK  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic       enable;
    logic [3:0] row, col;
    logic       blink_on, moved;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int m_row   = 0;
    int m_col   = 0;
    int m_moved = 0;
    int m_age   = 0;   // cycles since the blink phase last restarted
    int m_dir   = 0;   // 0 none, 1 up, 2 down, 3 left, 4 right
    int m_held  = 0;   // edges the current direction has been held, 0 = first

    cursor_controller #(
        .GRID_SIZE    (GRID),
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REPEAT),
        .BLINK_CYCLES (BLINK)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .enable   (enable),
        .row      (row),
        .col      (col),
        .blink_on (blink_on),
        .moved    (moved)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance n rising edges, then settle 2 time units past the last edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Model. A step happens on the first edge a direction is held, then
    // HOLD edges later, then every REPEAT edges after that.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_row = 0; m_col = 0; m_moved = 0; m_age = 0; m_dir = 0; m_held = 0;
            end else begin
                int ones;
                int d;
                bit stp;
                ones = int'(btn_up) + int'(btn_down) + int'(btn_left) + int'(btn_right);
                d = 0;
                if (ones == 1) d = btn_up ? 1 : btn_down ? 2 : btn_left ? 3 : 4;
                stp = 1'b0;
                if (!enable || d == 0) begin
                    m_dir  = 0;
                    m_held = 0;
                end else begin
                    if (d != m_dir) begin
                        m_dir  = d;
                        m_held = 0;
                    end else begin
                        m_held++;
                    end
                    stp = (m_held == 0) ||
                          (m_held >= HOLD && ((m_held - HOLD) % REPEAT) == 0);
                end
                if (stp) begin
                    case (d)
                        1: m_row = (m_row + GRID - 1) % GRID;
                        2: m_row = (m_row + 1) % GRID;
                        3: m_col = (m_col + GRID - 1) % GRID;
                        default: m_col = (m_col + 1) % GRID;
                    endcase
                    m_age = 0;
                end else begin
                    m_age++;
                end
                m_moved = stp ? 1 : 0;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("cyc_row",   int'(row),      m_row);
            chk("cyc_col",   int'(col),      m_col);
            chk("cyc_moved", int'(moved),    m_moved);
            chk("cyc_blink", int'(blink_on), ((m_age / BLINK) % 2 == 0) ? 1 : 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int mcount;
        int exp_blink [9];
        exp_blink = '{1, 0, 0, 0, 1, 1, 1, 0, 0};

        rst = 1'b1; enable = 1'b1;
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        #12;
        chk("rst_row",   int'(row),      0);
        chk("rst_col",   int'(col),      0);
        chk("rst_blink", int'(blink_on), 1);
        chk("rst_moved", int'(moved),    0);
        rst = 1'b0;

        // Single right pulse
        btn_right = 1'b1; cyc(1); btn_right = 1'b0;
        chk("t1_col",   int'(col),   1);
        chk("t1_row",   int'(row),   0);
        chk("t1_moved", int'(moved), 1);
        cyc(1);
        chk("t1_moved_low", int'(moved), 0);

        // Wrap at the edges
        btn_up = 1'b1; cyc(1); btn_up = 1'b0;
        chk("t2_row_wrap", int'(row), 8);
        cyc(1);
        btn_left = 1'b1; cyc(1); btn_left = 1'b0; cyc(1);
        btn_left = 1'b1; cyc(1); btn_left = 1'b0;
        chk("t2_col_wrap_left", int'(col), 8);
        cyc(1);
        btn_right = 1'b1; cyc(1); btn_right = 1'b0;
        chk("t2_col_wrap_right", int'(col), 0);
        cyc(1);
        btn_down = 1'b1; cyc(1); btn_down = 1'b0;
        chk("t2_row_wrap_down", int'(row), 0);
        cyc(1);

        // Hold down for 12 edges: steps at edges 1,5,7,9,11
        btn_down = 1'b1;
        mcount = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            mcount += int'(moved);
        end
        btn_down = 1'b0;
        chk("t3_row",    int'(row), 5);
        chk("t3_pulses", mcount,    5);
        cyc(1);

        // Chord: no movement
        btn_up = 1'b1; btn_left = 1'b1;
        mcount = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            mcount += int'(moved);
        end
        chk("t4_chord_row",   int'(row), 5);
        chk("t4_chord_col",   int'(col), 0);
        chk("t4_chord_moved", mcount,    0);

        // Disabled with down held: no movement; enable rise is a fresh press
        btn_up = 1'b0; btn_left = 1'b0; enable = 1'b0; btn_down = 1'b1;
        mcount = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            mcount += int'(moved);
        end
        chk("t4_dis_row",   int'(row), 5);
        chk("t4_dis_moved", mcount,    0);
        enable = 1'b1; cyc(1);
        chk("t4_enable_press", int'(row), 6);
        btn_down = 1'b0; cyc(1);

        // Blink phase while idle, then a step during the off phase
        for (int i = 0; i < 9; i++) begin
            cyc(1);
            chk("t5_blink_idle", int'(blink_on), exp_blink[i]);
        end
        btn_right = 1'b1; cyc(1); btn_right = 1'b0;
        chk("t5_step_blink", int'(blink_on), 1);
        chk("t5_step_col",   int'(col),      1);
        cyc(1); chk("t5_after1", int'(blink_on), 1);
        cyc(1); chk("t5_after2", int'(blink_on), 1);
        cyc(1); chk("t5_after3", int'(blink_on), 0);

        // Reset in REPEAT at row 3, then release with down held
        btn_up = 1'b1; cyc(7);
        chk("t6_row_before", int'(row), 3);
        rst = 1'b1; #1;
        chk("t6_async_row",   int'(row),      0);
        chk("t6_async_col",   int'(col),      0);
        chk("t6_async_blink", int'(blink_on), 1);
        chk("t6_async_moved", int'(moved),    0);
        btn_up = 1'b0; btn_down = 1'b1; #1;
        rst = 1'b0;
        cyc(1);
        chk("t6_fresh_row",   int'(row),   1);
        chk("t6_fresh_moved", int'(moved), 1);
        btn_down = 1'b0; cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
